// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scanner.
//   kp_state_t : scanner FSM states
//   COL_INIT   : column drive after reset (column 0 driven low)
//   ROWS_IDLE  : row pattern with no key pulling any row low
//   kp_code    : key code from row/column index (row*4 + col)
//   one_low    : {valid, row_idx}; valid only when exactly one row is low
//   col_index  : index of the low bit in a one-hot-low column drive
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

  localparam logic [3:0] COL_INIT  = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // row*4 + col is just the two indices concatenated.
  function automatic logic [3:0] kp_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  // Zero or several low rows are both treated as "no key"; several low rows is a ghost.
  function automatic logic [2:0] one_low(input logic [3:0] rows);
    logic [2:0] res;
    case (rows)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] res;
    case (col)
      4'b1101: res = 2'd1;
      4'b1011: res = 2'd2;
      4'b0111: res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two flip-flop synchroniser for a bus of independent asynchronous bits.
//   clk   : destination clock
//   reset : asynchronous, active-low reset (loads RST_VAL)
//   d     : asynchronous input bits
//   q     : synchronised output bits (two clk of latency)
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
// Scans a 4x4 active-low keypad one column per slot, debounces press and
// release over several slot samples, and reports one code per press.
//   clk       : system clock
//   reset     : asynchronous, active-low reset
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column drive, active-low one-hot
//   key_code  : last accepted key (row*4 + col), held until the next press
//   key_valid : one-cycle pulse when key_code takes a new accepted press
//   key_held  : high from acceptance until the release has been debounced
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LIMIT  = DW'(DEBOUNCE_SCANS);

  logic [3:0]    rows_s;
  logic [SW-1:0] slot_reg;
  logic          strobe;

  kp_state_t     state_reg, state_next;
  logic [DW-1:0] db_reg, db_next, db_inc;
  logic [1:0]    row_reg, row_next;
  logic [1:0]    col_reg, col_next;
  logic [3:0]    col_out_reg, col_out_next, col_rot;
  logic [3:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic          held_reg, held_next;

  logic [2:0]    sample;
  logic          sample_valid;
  logic [1:0]    sample_row;
  logic          rows_clear;
  logic          latched_low;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (ROWS_IDLE)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (rows_s)
  );

  // Free-running slot counter; the sample strobe is its last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_reg <= '0;
    end else if (slot_reg == SLOT_LAST) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_reg + SW'(1);
    end
  end

  assign strobe = (slot_reg == SLOT_LAST);

  assign sample       = one_low(rows_s);
  assign sample_valid = sample[2];
  assign sample_row   = sample[1:0];
  // Release needs all rows high; a multi-row ghost is neither press nor release.
  assign rows_clear   = (rows_s == ROWS_IDLE);
  assign latched_low  = ~rows_s[row_reg];
  assign col_rot      = {col_out_reg[2:0], col_out_reg[3]};
  // Saturating increment so the debounce count never wraps.
  assign db_inc       = (db_reg >= DB_LIMIT) ? db_reg : db_reg + DW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      db_reg      <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      col_out_reg <= COL_INIT;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      db_reg      <= db_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      col_out_reg <= col_out_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      held_reg    <= held_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_next      = db_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    col_out_next = col_out_reg;
    code_next    = code_reg;
    valid_next   = 1'b0;
    held_next    = held_reg;

    if (strobe) begin
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            row_next   = sample_row;
            col_next   = col_index(col_out_reg);
            db_next    = DW'(1);
            state_next = DEBOUNCE;
          end else begin
            col_out_next = col_rot;
          end
        end
        DEBOUNCE: begin
          if (sample_valid && (sample_row == row_reg)) begin
            if (db_inc >= DB_LIMIT) begin
              code_next  = kp_code(row_reg, col_reg);
              valid_next = 1'b1;
              held_next  = 1'b1;
              db_next    = '0;
              state_next = PRESSED;
            end else begin
              db_next = db_inc;
            end
          end else begin
            // Bounce or a different key: abandon this column and move on.
            db_next      = '0;
            state_next   = IDLE;
            col_out_next = col_rot;
          end
        end
        PRESSED: begin
          if (rows_clear) begin
            db_next    = DW'(1);
            state_next = RELEASE;
          end
        end
        RELEASE: begin
          if (rows_clear) begin
            if (db_inc >= DB_LIMIT) begin
              held_next    = 1'b0;
              db_next      = '0;
              state_next   = IDLE;
              col_out_next = col_rot;
            end else begin
              db_next = db_inc;
            end
          end else if (latched_low) begin
            // Contact bounced back: still the same press, no new pulse.
            db_next    = '0;
            state_next = PRESSED;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign col_out   = col_out_reg;
  assign key_code  = code_reg;
  assign key_valid = valid_reg;
  assign key_held  = held_reg;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan
// Randomised scenario bench for keypad_matrix_scan with a physical keypad
// model: a pressed key pulls its row low only while its column is driven.
module tb_keypad_matrix_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int PRESS_BUDGET   = (4 + DEBOUNCE_SCANS) * SCAN_DIV + 3 + 10;
  localparam int RELEASE_BUDGET = (DEBOUNCE_SCANS + 2) * SCAN_DIV + 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  logic [3:0]  last_code = '0;
  logic [3:0]  exp_code = '0;

  keypad_matrix_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
      end
    end
  end

  // Pulse recorder on the falling edge; the tasks run 2 ns after rising edges.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_code = key_code;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_held(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (key_held === val) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: col=%b code=%h valid=%b held=%b, want col=1110 code=0 valid=0 held=0",
               col_out, key_code, key_valid, key_held);
    end
    step(3);
    reset = 1'b1;
    exp_code = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checks++;
      if (col_out !== exp_col) begin
        failures++;
        $display("FAIL col_rotation k=%0d: col=%b want %b", k, col_out, exp_col);
      end
    end
    $display("test_reset done");
  endtask

  task automatic press_and_hold(input int idx, input int hold, input string name);
    bit ok;
    int base;
    base = pulse_cnt;
    pressed[idx] = 1'b1;
    wait_held(1'b1, PRESS_BUDGET, ok);
    step(2);
    exp_code = 4'(idx);
    checks++;
    if (!ok || (pulse_cnt - base) != 1 || last_code !== exp_code || key_code !== exp_code) begin
      failures++;
      $display("FAIL %s press: held_ok=%0d pulses=%0d code=%h last=%h, want held_ok=1 pulses=1 code=%h",
               name, ok, pulse_cnt - base, key_code, last_code, exp_code);
    end
    step(hold);
    checks++;
    if ((pulse_cnt - base) != 1 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL %s hold: pulses=%0d held=%b, want pulses=1 held=1", name, pulse_cnt - base, key_held);
    end
    pressed[idx] = 1'b0;
    wait_held(1'b0, RELEASE_BUDGET, ok);
    checks++;
    if (!ok || key_code !== exp_code) begin
      failures++;
      $display("FAIL %s release: held=%b code=%h, want held=0 code=%h", name, key_held, key_code, exp_code);
    end
    $display("%s key=%0d code=%h pulses=%0d", name, idx, key_code, pulse_cnt - base);
  endtask

  task automatic test_hold();
    bit ok;
    bit col_ok;
    int base;
    base = pulse_cnt;
    pressed[9] = 1'b1;
    wait_held(1'b1, PRESS_BUDGET, ok);
    step(2);
    exp_code = 4'h9;
    checks++;
    if (!ok || (pulse_cnt - base) != 1 || last_code !== 4'h9 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL hold_press: held_ok=%0d pulses=%0d code=%h, want held_ok=1 pulses=1 code=9",
               ok, pulse_cnt - base, key_code);
    end
    col_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (col_out !== 4'b1101 || key_held !== 1'b1) col_ok = 1'b0;
      step(1);
    end
    checks++;
    if (!col_ok || (pulse_cnt - base) != 1) begin
      failures++;
      $display("FAIL hold_frozen: col=%b held=%b pulses=%0d, want col=1101 held=1 pulses=1",
               col_out, key_held, pulse_cnt - base);
    end
    pressed[9] = 1'b0;
    wait_held(1'b0, RELEASE_BUDGET, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_release: held=%b want 0", key_held);
    end
    $display("test_hold code=%h pulses=%0d", key_code, pulse_cnt - base);
  endtask

  task automatic test_bounce();
    bit ok;
    int base;
    int pairs;
    base = pulse_cnt;
    pairs = $urandom_range(2, 4);
    // Alternate each slot so no two consecutive samples see the key.
    for (int i = 0; i < 2 * pairs; i++) begin
      pressed[3] = (i % 2 == 0);
      step(SCAN_DIV);
    end
    checks++;
    if ((pulse_cnt - base) != 0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL bounce_quiet: pulses=%0d held=%b, want pulses=0 held=0", pulse_cnt - base, key_held);
    end
    pressed[3] = 1'b1;
    wait_held(1'b1, PRESS_BUDGET, ok);
    step(2);
    exp_code = 4'h3;
    checks++;
    if (!ok || (pulse_cnt - base) != 1 || last_code !== 4'h3) begin
      failures++;
      $display("FAIL bounce_accept: held_ok=%0d pulses=%0d code=%h, want held_ok=1 pulses=1 code=3",
               ok, pulse_cnt - base, last_code);
    end
    $display("test_bounce pairs=%0d code=%h pulses=%0d", pairs, key_code, pulse_cnt - base);
  endtask

  task automatic test_release_bounce();
    bit ok;
    bit held_ok;
    int base;
    base = pulse_cnt;
    held_ok = 1'b1;
    pressed[3] = 1'b0;
    for (int i = 0; i < SCAN_DIV; i++) begin
      step(1);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    pressed[3] = 1'b1;
    for (int i = 0; i < SCAN_DIV; i++) begin
      step(1);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    pressed[3] = 1'b0;
    for (int i = 0; i < SCAN_DIV; i++) begin
      step(1);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL release_bounce_held: held dropped during bounce, want held=1");
    end
    wait_held(1'b0, RELEASE_BUDGET, ok);
    checks++;
    if (!ok || col_out !== 4'b1110 || (pulse_cnt - base) != 0) begin
      failures++;
      $display("FAIL release_done: held_ok=%0d col=%b pulses=%0d, want held_ok=1 col=1110 pulses=0",
               ok, col_out, pulse_cnt - base);
    end
    step(SCAN_DIV);
    checks++;
    if (col_out !== 4'b1101 || key_code !== exp_code) begin
      failures++;
      $display("FAIL release_rotate: col=%b code=%h, want col=1101 code=%h", col_out, key_code, exp_code);
    end
    $display("test_release_bounce col=%b held=%b pulses=%0d", col_out, key_held, pulse_cnt - base);
  endtask

  task automatic test_ghost(input int c, input int ra, input int rb);
    int base;
    base = pulse_cnt;
    pressed[ra*4+c] = 1'b1;
    pressed[rb*4+c] = 1'b1;
    step(80);
    checks++;
    if ((pulse_cnt - base) != 0 || key_held !== 1'b0 || key_code !== exp_code) begin
      failures++;
      $display("FAIL ghost col=%0d rows=%0d,%0d: pulses=%0d held=%b code=%h, want pulses=0 held=0 code=%h",
               c, ra, rb, pulse_cnt - base, key_held, key_code, exp_code);
    end
    pressed = '0;
    step(8);
    $display("test_ghost col=%0d rows=%0d,%0d pulses=%0d code=%h", c, ra, rb, pulse_cnt - base, key_code);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int idx;
    logic [3:0] tgt;
    idx = $urandom_range(0, 15);
    tgt = ~(4'b0001 << (idx % 4));
    base = pulse_cnt;
    pressed[idx] = 1'b1;
    for (int i = 0; i < 40 && col_out === tgt; i++) step(1);
    for (int i = 0; i < 40 && col_out !== tgt; i++) step(1);
    step(6);
    checks++;
    if (key_held !== 1'b0 || (pulse_cnt - base) != 0) begin
      failures++;
      $display("FAIL mid_debounce: held=%b pulses=%0d, want held=0 pulses=0", key_held, pulse_cnt - base);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_debounce: col=%b code=%h valid=%b held=%b, want 1110 0 0 0",
               col_out, key_code, key_valid, key_held);
    end
    exp_code = 4'h0;
    step(2);
    reset = 1'b1;
    base = pulse_cnt;
    wait_held(1'b1, PRESS_BUDGET, ok);
    step(2);
    exp_code = 4'(idx);
    checks++;
    if (!ok || (pulse_cnt - base) != 1 || key_code !== exp_code) begin
      failures++;
      $display("FAIL redetect_after_debounce_reset: pulses=%0d code=%h, want pulses=1 code=%h",
               pulse_cnt - base, key_code, exp_code);
    end
    step(10);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_pressed: col=%b code=%h valid=%b held=%b, want 1110 0 0 0",
               col_out, key_code, key_valid, key_held);
    end
    exp_code = 4'h0;
    step(2);
    reset = 1'b1;
    base = pulse_cnt;
    wait_held(1'b1, PRESS_BUDGET, ok);
    step(2);
    exp_code = 4'(idx);
    checks++;
    if (!ok || (pulse_cnt - base) != 1 || key_code !== exp_code) begin
      failures++;
      $display("FAIL redetect_after_pressed_reset: pulses=%0d code=%h, want pulses=1 code=%h",
               pulse_cnt - base, key_code, exp_code);
    end
    pressed[idx] = 1'b0;
    wait_held(1'b0, RELEASE_BUDGET, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_release: held=%b want 0", key_held);
    end
    $display("test_reset_mid key=%0d code=%h", idx, key_code);
  endtask

  task automatic test_back_to_back();
    int idx;
    idx = $urandom_range(0, 15);
    press_and_hold(idx, $urandom_range(0, 20), "back_to_back_1");
    press_and_hold(idx, $urandom_range(0, 20), "back_to_back_2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      press_and_hold($urandom_range(0, 15), $urandom_range(0, 40), "random");
    end
  endtask

  initial begin
    int c;
    int ra;
    int rb;
    test_reset();
    test_hold();
    test_bounce();
    test_release_bounce();
    test_ghost(0, 1, 3);
    c  = $urandom_range(0, 3);
    ra = $urandom_range(0, 3);
    rb = (ra + $urandom_range(1, 3)) % 4;
    test_ghost(c, ra, rb);
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
